// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : UART (8N1) framed-image loader that writes 14-bit words into the
//            program memory and holds the CPU in reset until a good image is in.
//            Optional checksum byte enabled by PROG_LOADER_CHKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int         c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [7:0] c_SYNC    = 8'hA5;
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_H  = 3'd1,
        S_CNT_L  = 3'd2,
        S_DATA_H = 3'd3,
        S_DATA_L = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // ---------------------------------------------------------------- receiver
    logic               r_rx_s1, r_rx_s2, r_rx_d;
    rx_state_t          r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_rx_byte, w_rx_byte_nxt;
    logic               r_byte_vld, w_byte_vld_nxt;
    logic               r_frame_err, w_frame_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_d      <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_bit_idx   <= '0;
            r_rx_byte   <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_s1     <= rx_i;
            r_rx_s2     <= r_rx_s1;
            r_rx_d      <= r_rx_s2;
            r_rx_state  <= w_rx_state_nxt;
            r_rx_cnt    <= w_rx_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_rx_byte   <= w_rx_byte_nxt;
            r_byte_vld  <= w_byte_vld_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt  = r_rx_state;
        w_rx_cnt_nxt    = r_rx_cnt + 1'b1;
        w_bit_idx_nxt   = r_bit_idx;
        w_rx_byte_nxt   = r_rx_byte;
        w_byte_vld_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (!r_rx_s2 && r_rx_d)
                    w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch
                if (r_rx_cnt == c_HALF_M1) begin
                    w_rx_cnt_nxt   = '0;
                    w_bit_idx_nxt  = '0;
                    w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_FULL_M1) begin
                    w_rx_cnt_nxt  = '0;
                    w_rx_byte_nxt = {r_rx_s2, r_rx_byte[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7)
                        w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_FULL_M1) begin
                    w_rx_cnt_nxt    = '0;
                    w_byte_vld_nxt  = r_rx_s2;
                    w_frame_err_nxt = !r_rx_s2;
                    w_rx_state_nxt  = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------ frame parser
    state_t            r_state, w_state_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
    logic              r_cpu_rst, w_cpu_rst_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [2:0]        r_cnt_h, w_cnt_h_nxt;
    logic [10:0]       r_n, w_n_nxt;
    logic [5:0]        r_hi, w_hi_nxt;
    logic              w_go_done, w_go_err, w_data_end, w_last;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]        r_sum, w_sum_nxt;
`endif

    assign w_last = (r_wr_addr == ADDR_W'(r_n - 11'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt_h   <= '0;
            r_n       <= '0;
            r_hi      <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_cpu_rst <= w_cpu_rst_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_cnt_h   <= w_cnt_h_nxt;
            r_n       <= w_n_nxt;
            r_hi      <= w_hi_nxt;
`ifdef PROG_LOADER_CHKSUM_EN
            r_sum     <= w_sum_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_en ? r_wr_addr + 1'b1 : r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_cpu_rst_nxt = r_cpu_rst;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_err_nxt     = r_err;
        w_cnt_h_nxt   = r_cnt_h;
        w_n_nxt       = r_n;
        w_hi_nxt      = r_hi;
        w_go_done     = 1'b0;
        w_go_err      = 1'b0;
        w_data_end    = 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
        w_sum_nxt     = r_byte_vld ? r_sum + r_rx_byte : r_sum;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (r_byte_vld && r_rx_byte == c_SYNC) begin
                    w_state_nxt   = S_CNT_H;
                    w_busy_nxt    = 1'b1;
                    w_cpu_rst_nxt = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_wr_addr_nxt = '0;
`ifdef PROG_LOADER_CHKSUM_EN
                    w_sum_nxt     = '0;
`endif
                end
            end
            S_CNT_H: begin
                if (r_byte_vld) begin
                    if (|r_rx_byte[7:3]) begin
                        w_go_err = 1'b1;
                    end else begin
                        w_cnt_h_nxt = r_rx_byte[2:0];
                        w_state_nxt = S_CNT_L;
                    end
                end
            end
            S_CNT_L: begin
                if (r_byte_vld) begin
                    w_n_nxt = {r_cnt_h, r_rx_byte};
                    if ({r_cnt_h, r_rx_byte} == 11'd0)
                        w_data_end = 1'b1;
                    else
                        w_state_nxt = S_DATA_H;
                end
            end
            S_DATA_H: begin
                if (r_byte_vld) begin
                    w_hi_nxt    = r_rx_byte[5:0];
                    w_state_nxt = S_DATA_L;
                end
            end
            S_DATA_L: begin
                if (r_byte_vld) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_data_nxt = DATA_W'({r_hi, r_rx_byte});
                    if (w_last)
                        w_data_end = 1'b1;
                    else
                        w_state_nxt = S_DATA_H;
                end
            end
`ifdef PROG_LOADER_CHKSUM_EN
            S_CHK: begin
                if (r_byte_vld) begin
                    if (r_rx_byte == r_sum)
                        w_go_done = 1'b1;
                    else
                        w_go_err = 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_data_end) begin
`ifdef PROG_LOADER_CHKSUM_EN
            w_state_nxt = S_CHK;
`else
            w_go_done = 1'b1;
`endif
        end

        if (r_frame_err && r_busy)
            w_go_err = 1'b1;

        if (w_go_done) begin
            w_state_nxt   = S_DONE;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
            w_err_nxt     = 1'b0;
            w_cpu_rst_nxt = 1'b0;
        end
        // Error wins; the CPU stays held so a partial image never runs
        if (w_go_err) begin
            w_state_nxt   = S_ERR;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_err_nxt     = 1'b1;
            w_cpu_rst_nxt = 1'b1;
            w_wr_en_nxt   = 1'b0;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign cpu_rst = r_cpu_rst;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Self-checking bench for prog_loader with a byte-stream reference
//            model; honours PROG_LOADER_CHKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_i = 1'b1;
    logic        wr_en, cpu_rst, busy, done, err;
    logic [10:0] wr_addr;
    logic [13:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [24:0] exp_q[$];
    logic [24:0] cap_q[$];
    logic [7:0]  fq[$];

    // reference model state
    int         m_phase;   // 0 hunting, 1 count hi, 2 count lo, 3 data, 4 checksum
    bit         m_busy, m_done, m_err;
    int         m_n, m_idx;
    logic [7:0] m_sum, m_hi;

    always #5 clk = ~clk;

    prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(11), .DATA_W(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_i    (rx_i),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_phase = 0; m_busy = 0; m_done = 0; m_err = 0;
        exp_q.delete();
    endtask
    task automatic m_ok();
        m_phase = 0; m_busy = 0; m_done = 1; m_err = 0;
    endtask
    task automatic m_fail();
        m_phase = 0; m_busy = 0; m_done = 0; m_err = 1;
    endtask
    task automatic m_data_end();
`ifdef PROG_LOADER_CHKSUM_EN
        m_phase = 4;
`else
        m_ok();
`endif
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_phase)
            0: if (b == 8'hA5) begin
                m_phase = 1; m_busy = 1; m_done = 0; m_err = 0; m_sum = 0; m_idx = 0;
            end
            1: begin
                m_sum += b;
                if (b[7:3] != 5'd0) m_fail();
                else begin m_n = int'(b[2:0]) * 256; m_phase = 2; end
            end
            2: begin
                m_sum += b;
                m_n += int'(b);
                if (m_n == 0) m_data_end(); else m_phase = 3;
            end
            3: begin
                m_sum += b;
                if (m_idx % 2 == 0) m_hi = b;
                else exp_q.push_back({11'(m_idx / 2), m_hi[5:0], b});
                m_idx++;
                if (m_idx == 2 * m_n) m_data_end();
            end
            default: if (b == m_sum) m_ok(); else m_fail();
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop);
        rx_i = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin rx_i = b[i]; tick(CPB); end
        rx_i = stop; tick(CPB);
        rx_i = 1'b1; tick(3 * CPB + int'($urandom_range(0, 4)));
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_busy"},    busy,    m_busy);
        chk({tag, "_done"},    done,    m_done);
        chk({tag, "_err"},     err,     m_err);
        chk({tag, "_cpu_rst"}, cpu_rst, !m_done);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        model_byte(b);
        send_raw(b, 1'b1);
        check_status(tag);
    endtask

    task automatic send_ferr(input logic [7:0] b, input string tag);
        send_raw(b, 1'b0);
        if (m_phase != 0) m_fail();
        check_status(tag);
    endtask

    task automatic send_fq(input string tag);
        foreach (fq[i]) send_byte(fq[i], tag);
    endtask

    task automatic check_frame1_writes(input string tag);
        chk({tag, "_nwr"}, cap_q.size(), 2);
        if (cap_q.size() >= 2) begin
            chk({tag, "_wr0"}, cap_q[0], {11'd0, 14'h3005});
            chk({tag, "_wr1"}, cap_q[1], {11'd1, 14'h3E03});
        end
    endtask

    // Every write strobe must match the next word the model expects
    always @(negedge clk) begin : compare
        logic [24:0] e;
        if (chk_en && !rst) begin
            if (wr_en === 1'b1) begin
                cap_q.push_back({wr_addr, wr_data});
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                             wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", {wr_addr, wr_data}, e);
                end
            end else begin
                chk("wr_en_known", wr_en, 1'b0);
            end
            chk("cpu_rst_vs_done", cpu_rst, !done);
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] b, s, cnt_h;
        int         n, fpos;
        m_reset();
        tick(3);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick(5);

        // good two-word image
        cap_q.delete();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h78};
        send_fq("t1");
        check_frame1_writes("t1");
        chk("t1_done_lit", done, 1);
        chk("t1_cpu_rst_lit", cpu_rst, 0);
        chk("t1_err_lit", err, 0);

        // same image, wrong checksum
        cap_q.delete();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h79};
        send_fq("t2");
        check_frame1_writes("t2");
`ifdef PROG_LOADER_CHKSUM_EN
        chk("t2_err_lit", err, 1);
        chk("t2_cpu_rst_lit", cpu_rst, 1);
`else
        chk("t2_done_lit", done, 1);
`endif

        // framing error on the first data byte
        cap_q.delete();
        fq = '{8'hA5, 8'h00, 8'h01};
        send_fq("t3");
        send_ferr(8'h30, "t3f");
        chk("t3_err_lit", err, 1);
        chk("t3_busy_lit", busy, 0);
        chk("t3_nwr", cap_q.size(), 0);

        // glitch and stray bytes, then a good image
        rx_i = 1'b0; tick(1); rx_i = 1'b1; tick(4 * CPB);
        check_status("t4g");
        send_byte(8'h00, "t4j");
        send_byte(8'hFF, "t4j");
        cap_q.delete();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h78};
        send_fq("t4");
        check_frame1_writes("t4");
        chk("t4_done_lit", done, 1);

        // reset after the first write, then a full image
        cap_q.delete();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05};
        send_fq("t5a");
        chk("t5_first_wr", cap_q.size(), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_wr_en", wr_en, 0);
        chk("t5_rst_wr_addr", wr_addr, 0);
        chk("t5_rst_wr_data", wr_data, 0);
        chk("t5_rst_cpu_rst", cpu_rst, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_err", err, 0);
        m_reset();
        tick(2);
        rst = 1'b0;
        tick(3);
        cap_q.delete();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h78};
        send_fq("t5");
        check_frame1_writes("t5");
        chk("t5_done_lit", done, 1);

        // bad count high byte; then a one-word image
        fq = '{8'hA5, 8'h08};
        send_fq("t6a");
        chk("t6_err_lit", err, 1);
        send_byte(8'h00, "t6a");
        cap_q.delete();
        fq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
        send_fq("t6b");
        chk("t6_nwr", cap_q.size(), 1);
        if (cap_q.size() >= 1) chk("t6_wr0", cap_q[0], {11'd0, 14'h1234});
        chk("t6_done_lit", done, 1);

        // randomized frames with junk, bad counts, bad sums and framing errors
        for (int it = 0; it < 25; it++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, "rj");
            end
            n = int'($urandom_range(0, 4));
            cnt_h = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 255)) : 8'h00;
            fq.delete();
            fq.push_back(8'hA5);
            fq.push_back(cnt_h);
            fq.push_back(8'(n));
            s = cnt_h + 8'(n);
            for (int k = 0; k < 2 * n; k++) begin
                b = 8'($urandom);
                fq.push_back(b);
                s += b;
            end
            fq.push_back(($urandom_range(0, 3) == 0) ? s + 8'd1 : s);
            fpos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, fq.size() - 1)) : fq.size();
            for (int k = 0; k < fq.size(); k++) begin
                if (k == fpos) begin
                    send_ferr(fq[k], "rf");
                    break;
                end
                send_byte(fq[k], "rb");
            end
        end

        tick(10);
        chk("final_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
